// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: FSM encodings, owner ids and address map shared by the arbiter and its checker.
// The address check is compiled in only when MEM_ARB_ADDR_CHECK_EN is defined.
package mem_bus_arbiter_pkg;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic OWN_M0 = 1'b0;
   localparam logic OWN_M1 = 1'b1;
   localparam logic [3:0] MMIO_NIBBLE_DEF = 4'h4;
   localparam logic [31:0] MMIO_LED       = 32'h4000_000C;
   localparam logic [31:0] MMIO_DIGI      = 32'h4000_0010;
   localparam logic [31:0] MMIO_UART_DATA = 32'h4000_0018;
   localparam logic [31:0] MMIO_UART_STAT = 32'h4000_001C;
   localparam logic [31:0] MMIO_UART_CTRL = 32'h4000_0020;
   typedef struct packed {
      logic is_mmio;
      logic in_ram;
      logic misaligned;
   } addr_chk_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: two request ports (indexed by master id) plus the single memory port.
// Signal suffixes are from the arbiter's point of view; slave is the arbiter side.
interface mem_bus_arbiter_if;
   logic [1:0]       req_i;
   logic [1:0]       we_i;
   logic [1:0][31:0] addr_i;
   logic [1:0][31:0] wdata_i;
   logic [1:0]       done_o;
   logic [31:0]      rdata_o;
   logic             err_o;
   logic [31:0]      mem_addr_o;
   logic [31:0]      mem_wdata_o;
   logic             mem_read_o;
   logic             mem_write_o;
   logic [31:0]      mem_rdata_i;
   logic             busy_o;
   modport slave (
      input  req_i, we_i, addr_i, wdata_i, mem_rdata_i,
      output done_o, rdata_o, err_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o, busy_o
   );
   modport master (
      output req_i, we_i, addr_i, wdata_i, mem_rdata_i,
      input  done_o, rdata_o, err_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o, busy_o
   );
endinterface

// File: rtl/mem_bus_arbiter_addr_check.sv
// mem_bus_arbiter_addr_check: classifies a byte address as MMIO, inside RAM, and/or misaligned.
// Instantiated only when MEM_ARB_ADDR_CHECK_EN is defined.
module mem_bus_arbiter_addr_check
   import mem_bus_arbiter_pkg::*;
#(
   parameter int RAM_SIZE = 256,
   parameter int RAM_SIZE_BIT = 8,
   parameter logic [3:0] MMIO_NIBBLE = MMIO_NIBBLE_DEF
) (
   input  logic [31:0] addr_i,
   output addr_chk_t   chk_o
);
   logic [29:0] word;
   assign word = addr_i[31:2];
   assign chk_o.is_mmio = addr_i[31:28] == MMIO_NIBBLE;
   assign chk_o.in_ram = (word >> RAM_SIZE_BIT) == 30'd0 && {2'b00, word} < 32'(RAM_SIZE);
   assign chk_o.misaligned = |addr_i[1:0];
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-master arbiter driving the data-memory/MMIO port one cycle per grant.
// Define MEM_ARB_ADDR_CHECK_EN to suppress and flag out-of-map or misaligned accesses.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int RAM_SIZE = 256,
   parameter int RAM_SIZE_BIT = 8,
   parameter logic [3:0] MMIO_NIBBLE = MMIO_NIBBLE_DEF
) (
   input logic clk_i,
   input logic rst_ni,
   mem_bus_arbiter_if.slave bus
);
   logic [1:0]  state_q, state_d;
   logic        owner_q, owner_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [1:0]  elig;
   logic        gnt, pick, access, bad;

   assign access = state_q == ST_ACCESS;
   // In DONE the owner's request is stale; owner_q also serves as the round-robin last owner.
   assign elig = state_q == ST_IDLE ? bus.req_i
               : state_q == ST_DONE ? bus.req_i & ~(2'b01 << owner_q) : 2'b00;
   assign gnt = |elig;
   assign pick = &elig ? ~owner_q : elig[1];

   always_comb begin
      state_d = access ? ST_DONE : gnt ? ST_ACCESS : ST_IDLE;
      owner_d = gnt ? pick : owner_q;
      we_d = gnt ? bus.we_i[pick] : we_q;
      addr_d = gnt ? bus.addr_i[pick] : addr_q;
      wdata_d = gnt ? bus.wdata_i[pick] : wdata_q;
      rdata_d = !access ? rdata_q : bad ? 32'd0 : we_q ? rdata_q : bus.mem_rdata_i;
      err_d = access ? bad : err_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_M1;
         we_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q <= we_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q <= err_d;
      end
   end

`ifdef MEM_ARB_ADDR_CHECK_EN
   addr_chk_t chk;
   mem_bus_arbiter_addr_check #(
      .RAM_SIZE(RAM_SIZE),
      .RAM_SIZE_BIT(RAM_SIZE_BIT),
      .MMIO_NIBBLE(MMIO_NIBBLE)
   ) u_addr_check (
      .addr_i(addr_q),
      .chk_o(chk)
   );
   assign bad = chk.misaligned | (~chk.is_mmio & ~chk.in_ram);
`else
   // Unchecked build forwards every access, so the address-map parameters shape nothing here.
   if (RAM_SIZE < 1 || RAM_SIZE > (1 << RAM_SIZE_BIT) || MMIO_NIBBLE == 4'h0) begin : g_map_unchecked
   end
   assign bad = 1'b0;
`endif

   // Strobes are gated by reset combinationally so an aborted ACCESS never writes.
   assign bus.mem_read_o = access & ~we_q & rst_ni & ~bad;
   assign bus.mem_write_o = access & we_q & rst_ni & ~bad;
   assign bus.mem_addr_o = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.done_o = state_q != ST_DONE ? 2'b00 : owner_q == OWN_M0 ? 2'b01 : 2'b10;
   assign bus.rdata_o = rdata_q;
   assign bus.err_o = err_q;
   assign bus.busy_o = state_q != ST_IDLE;
endmodule
